// File: rtl/seq_div.sv
// seq_div: unsigned restoring divider producing one quotient bit per clock, MSB first.
// Latency: DATAWIDTH+1 edges from the capture edge to done for b != 0; 1 edge for b == 0.
// start is accepted only in IDLE or DONE and ignored while iterating; results hold until the next completion.
module seq_div #(
  parameter int DATAWIDTH = 64
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] quot,
  output logic [DATAWIDTH-1:0] rem,
  output logic                 divz
);

  localparam int            CW   = $clog2(DATAWIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Iteration counter: number of quotient bits already produced.
  logic [CW-1:0] cnt;

  // The dividend register doubles as the quotient accumulator: each step
  // shifts out the next dividend bit at the top and shifts in the new
  // quotient bit at the bottom, so after DATAWIDTH steps it holds the quotient.
  logic [DATAWIDTH-1:0] dvd;
  logic [DATAWIDTH-1:0] dsr;
  logic [DATAWIDTH-1:0] prem;

  logic [DATAWIDTH:0]   partial;
  logic [DATAWIDTH-1:0] diff;
  logic [DATAWIDTH-1:0] prem_nxt;
  logic [DATAWIDTH-1:0] dvd_nxt;
  logic                 ge;
  logic                 accept;
  logic                 bzero;
  logic                 last;

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign bzero  = (b == '0);
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == LAST);

  // One restoring step. The subtraction is done modulo 2^DATAWIDTH: it is only
  // used when partial >= divisor, and then the true difference is below the
  // divisor, so the discarded top bit is always zero.
  always_comb begin
    partial  = {prem, dvd[DATAWIDTH-1]};
    ge       = (partial >= {1'b0, dsr});
    diff     = partial[DATAWIDTH-1:0] - dsr;
    prem_nxt = ge ? diff : partial[DATAWIDTH-1:0];
    dvd_nxt  = {dvd[DATAWIDTH-2:0], ge};
  end

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a zero divisor skips RUN and completes immediately.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = bzero ? DONE : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      dvd  <= '0;
      dsr  <= '0;
      prem <= '0;
      cnt  <= '0;
      quot <= '0;
      rem  <= '0;
      divz <= 1'b0;
    end else if (accept) begin
      dvd  <= a;
      dsr  <= b;
      prem <= '0;
      cnt  <= '0;
      if (bzero) begin
        quot <= '1;
        rem  <= a;
        divz <= 1'b1;
      end
    end else if (state == RUN) begin
      dvd  <= dvd_nxt;
      prem <= prem_nxt;
      cnt  <= cnt + CW'(1);
      if (last) begin
        quot <= dvd_nxt;
        rem  <= prem_nxt;
        divz <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Directed and random checks of seq_div against a plain-arithmetic reference.
module tb_seq_div;

  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         divz;

  int errors = 0;
  int checks = 0;

  seq_div #(.DATAWIDTH(W)) dut (
    .Clk  (clk),
    .Rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .quot (quot),
    .rem  (rem),
    .divz (divz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: ordinary integer division, with the zero-divisor convention.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                       output logic [W-1:0] eq, output logic [W-1:0] er, output logic ez);
    if (tbv == '0) begin
      eq = '1;
      er = ta;
      ez = 1'b1;
    end else begin
      eq = ta / tbv;
      er = ta % tbv;
      ez = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Called at the negedge where start/a/b for this division are being driven.
  // intr_at > 0 pulses a competing start with 50/5 before edge (capture + intr_at).
  // chain = 1 drives a new start with ca/cb during the DONE cycle and returns.
  task automatic finish_div(input logic [W-1:0] ta, input logic [W-1:0] tbv, input string tag,
                            input int intr_at, input bit chain,
                            input logic [W-1:0] ca, input logic [W-1:0] cb);
    logic [W-1:0] eq, er;
    logic         ez;
    int           n, nb;
    model(ta, tbv, eq, er, ez);
    @(negedge clk);
    n  = 1;
    nb = 0;
    while (1) begin
      if (done === 1'b1 || n >= 200) break;
      if (busy === 1'b1) nb++;
      start = (n == intr_at);
      if (start) begin
        a = 64'd50;
        b = 64'd5;
      end else begin
        a = rnd64();
        b = rnd64();
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(n), (tbv == '0) ? 64'd1 : 64'd65);
    check({tag, "_busy_cycles"}, 64'(nb), (tbv == '0) ? 64'd0 : 64'd64);
    check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    check({tag, "_quot"}, quot, eq);
    check({tag, "_rem"}, rem, er);
    check({tag, "_divz"}, 64'(divz), 64'(ez));
    if (chain) begin
      start = 1'b1;
      a = ca;
      b = cb;
    end else begin
      @(negedge clk);
      check({tag, "_done_width"}, 64'(done), 64'd0);
      check({tag, "_quot_hold"}, quot, eq);
    end
  endtask

  task automatic run_div(input logic [W-1:0] ta, input logic [W-1:0] tbv, input string tag);
    @(negedge clk);
    start = 1'b1;
    a = ta;
    b = tbv;
    finish_div(ta, tbv, tag, 0, 1'b0, '0, '0);
  endtask

  initial begin
    int nd;
    logic [W-1:0] ra, rb;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_quot", quot, 64'd0);
    check("rst_rem", rem, 64'd0);
    check("rst_divz", 64'(divz), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_div(64'd100, 64'd7, "d100_7");
    run_div(64'h1234, 64'd0, "divzero");
    run_div(64'd5, 64'd9, "d5_9");
    run_div('1, 64'd1, "max_1");
    run_div('1, '1, "max_max");
    run_div(64'd100, 64'd7, "clear_divz");

    // Competing start during RUN must be ignored.
    @(negedge clk);
    start = 1'b1;
    a = 64'd100;
    b = 64'd7;
    finish_div(64'd100, 64'd7, "ignore_start", 10, 1'b0, '0, '0);

    // Reset mid-run: everything clears at once and no done follows.
    @(negedge clk);
    start = 1'b1;
    a = 64'd100;
    b = 64'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_quot", quot, 64'd0);
    check("midrst_rem", rem, 64'd0);
    check("midrst_divz", 64'(divz), 64'd0);
    @(negedge clk);
    start = 1'b1;
    a = 64'd5;
    b = 64'd0;
    repeat (2) @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    nd = 0;
    repeat (80) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) nd++;
    end
    check("midrst_no_activity", 64'(nd), 64'd0);
    run_div(64'd9, 64'd4, "after_rst");

    // Back-to-back: new start accepted in the DONE cycle.
    @(negedge clk);
    start = 1'b1;
    a = 64'd100;
    b = 64'd7;
    finish_div(64'd100, 64'd7, "b2b_first", 0, 1'b1, 64'd81, 64'd9);
    finish_div(64'd81, 64'd9, "b2b_second", 0, 1'b0, '0, '0);

    // Random operands of varied magnitude, with occasional zero divisors.
    for (int i = 0; i < 20; i++) begin
      ra = rnd64() >> $urandom_range(0, 63);
      rb = rnd64() >> $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) rb = '0;
      run_div(ra, rb, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
